// File: rtl/tm_qm0_sched_pkg.sv
// tm_qm0_sched_pkg -- shared definitions for the first-level queue scheduler.
//
// Contents:
//   QID_NBITS_DEF / NQ_DEF : default queue-id width and queue count (4 bits,
//                            16 queues); override through module parameters.
//   init_state_e           : INIT / RUN state encoding for the init-wait FSM.
//   ERR_*                  : err_code values reported when TM_QM0_SCHED_ERR_EN
//                            is defined.
package tm_qm0_sched_pkg;

  localparam int QID_NBITS_DEF = 4;
  localparam int NQ_DEF = 2 ** QID_NBITS_DEF;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } init_state_e;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_ACK_EMPTY    = 2'd1;  // ack with no outstanding tag
  localparam logic [1:0] ERR_ENQ_ACTIVE   = 2'd2;  // enq_to_empty on an active qid
  localparam logic [1:0] ERR_DEQ_INACTIVE = 2'd3;  // deq_ack on an inactive qid

endpackage

// File: rtl/sfifo2f_fo.sv
// sfifo2f_fo -- small synchronous FIFO with fall-through head output.
//
// The head entry is visible on dout_o whenever empty_o is low, so a consumer
// can look at the head and pop it in the same cycle. Writes while full and
// reads while empty are ignored.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_i, din_i       : push request and data
//   rd_i              : pop request
//   dout_o            : current head entry
//   full_o, empty_o   : occupancy flags
module sfifo2f_fo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_wr, do_rd;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_wr   = wr_i & ~full_o;
  assign do_rd   = rd_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/tm_qm0_rr_pick.sv
// tm_qm0_rr_pick -- combinational round-robin find-first.
//
// Searches vec_i upward starting at start_i, wrapping from NQ-1 to 0, and
// returns the first set position.
//
// Ports:
//   vec_i   : candidate bitmap (NQ bits)
//   start_i : search start position
//   found_o : at least one bit of vec_i is set
//   qid_o   : first set position at or after start_i (start_i when none)
module tm_qm0_rr_pick
  import tm_qm0_sched_pkg::*;
#(
  parameter int QID_NBITS = QID_NBITS_DEF
) (
  input  logic [2**QID_NBITS-1:0] vec_i,
  input  logic [QID_NBITS-1:0]    start_i,
  output logic                    found_o,
  output logic [QID_NBITS-1:0]    qid_o
);

  localparam int NQ = 2 ** QID_NBITS;

  // Walk offsets from far to near so the closest hit is the last assignment.
  // The offset addition wraps naturally at the qid width.
  always_comb begin
    found_o = 1'b0;
    qid_o   = start_i;
    for (int i = NQ - 1; i >= 0; i--) begin
      logic [QID_NBITS-1:0] idx;
      idx = start_i + QID_NBITS'(i);
      if (vec_i[idx]) begin
        found_o = 1'b1;
        qid_o   = idx;
      end
    end
  end

endmodule

// File: rtl/tm_qm0_sched.sv
// tm_qm0_sched -- first-level queue dequeue scheduler / request sequencer
// in front of the per-queue depth tracker (tm_qm0_depth).
//
// Forwards egress enqueues to the tracker, keeps an "active" (non-empty)
// bitmap from the tracker's enq_to_empty / deq_from_emptyp2 responses and
// issues round-robin dequeues whenever the port scheduler is ready. Traffic
// is held off for INIT_CYCLES after reset while the tracker clears its RAM.
//
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   up_enq_req/up_enq_qid        : enqueue request from the egress processor
//   up_enq_rdy                   : enqueue accepted when req & rdy
//   sch_rdy                      : port scheduler can take one dequeue
//   enq_req/enq_qid              : enqueue command to the tracker
//   deq_req/deq_qid              : dequeue command to the tracker / issued strobe
//   enq_ack/enq_to_empty         : tracker enqueue response (in order)
//   deq_ack/deq_from_emptyp2     : tracker dequeue response (in order)
//   init_done                    : init wait complete
//   active_cnt                   : number of active queues
//   err/err_code                 : only with TM_QM0_SCHED_ERR_EN defined; sticky
//                                  first-error flag and code
module tm_qm0_sched
  import tm_qm0_sched_pkg::*;
#(
  parameter int QID_NBITS   = QID_NBITS_DEF,
  parameter int TAG_DEPTH   = 4,
  parameter int INIT_CYCLES = 2 ** QID_NBITS + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_enq_req,
  input  logic [QID_NBITS-1:0] up_enq_qid,
  output logic                 up_enq_rdy,
  input  logic                 sch_rdy,
  output logic                 enq_req,
  output logic [QID_NBITS-1:0] enq_qid,
  output logic                 deq_req,
  output logic [QID_NBITS-1:0] deq_qid,
  input  logic                 enq_ack,
  input  logic                 enq_to_empty,
  input  logic                 deq_ack,
  input  logic                 deq_from_emptyp2,
  output logic                 init_done,
  output logic [QID_NBITS:0]   active_cnt
`ifdef TM_QM0_SCHED_ERR_EN
  ,
  output logic                 err,
  output logic [1:0]           err_code
`endif
);

  localparam int NQ    = 2 ** QID_NBITS;
  localparam int CNT_W = $clog2(INIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  // ---------------- init wait FSM ----------------
  init_state_e      state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == CNT_LAST) state_d = ST_RUN;
        else                        init_cnt_d = init_cnt_q + 1'b1;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign init_done = run;

  // ---------------- enqueue path ----------------
  logic                 enq_full, enq_empty, enq_accept, enq_pop;
  logic [QID_NBITS-1:0] enq_head;
  logic                 enq_req_q;
  logic [QID_NBITS-1:0] enq_qid_q;

  assign up_enq_rdy = run & ~enq_full;
  assign enq_accept = up_enq_req & up_enq_rdy;
  assign enq_pop    = enq_ack & ~enq_empty;

  // The tag is pushed on the accept edge so the full flag already covers the
  // request that is being forwarded this cycle.
  sfifo2f_fo #(.WIDTH(QID_NBITS), .DEPTH(TAG_DEPTH)) u_enq_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (enq_accept),
    .din_i   (up_enq_qid),
    .rd_i    (enq_ack),
    .dout_o  (enq_head),
    .full_o  (enq_full),
    .empty_o (enq_empty)
  );

  // ---------------- dequeue path ----------------
  logic [NQ-1:0]        active_q, active_d;
  logic [NQ-1:0]        pending_q, pending_d;
  logic [NQ-1:0]        eligible;
  logic [QID_NBITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                 pick_found, deq_issue, deq_full, deq_empty, deq_pop;
  logic [QID_NBITS-1:0] pick_qid, deq_head;
  logic                 deq_req_q;
  logic [QID_NBITS-1:0] deq_qid_q;
  logic [QID_NBITS:0]   active_cnt_q, active_cnt_d;

  // A queue with a dequeue in flight is skipped until its ack returns, so the
  // scheduler can never run a queue below its tracked depth.
  assign eligible = active_q & ~pending_q;

  tm_qm0_rr_pick #(.QID_NBITS(QID_NBITS)) u_rr_pick (
    .vec_i   (eligible),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .qid_o   (pick_qid)
  );

  assign deq_issue = run & sch_rdy & pick_found & ~deq_full;
  assign deq_pop   = deq_ack & ~deq_empty;

  sfifo2f_fo #(.WIDTH(QID_NBITS), .DEPTH(TAG_DEPTH)) u_deq_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (deq_issue),
    .din_i   (pick_qid),
    .rd_i    (deq_ack),
    .dout_o  (deq_head),
    .full_o  (deq_full),
    .empty_o (deq_empty)
  );

  // Dequeue clears are applied before the enqueue set so a set on the same
  // qid wins; a drained queue gets re-activated by a racing enqueue.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    if (deq_pop) begin
      pending_d[deq_head] = 1'b0;
      if (!deq_from_emptyp2) active_d[deq_head] = 1'b0;
    end
    if (enq_pop && enq_to_empty) active_d[enq_head] = 1'b1;
    if (deq_issue) begin
      pending_d[pick_qid] = 1'b1;
      rr_ptr_d            = pick_qid + QID_NBITS'(1);
    end
    active_cnt_d = '0;
    for (int i = 0; i < NQ; i++) begin
      active_cnt_d = active_cnt_d + (QID_NBITS+1)'(active_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      active_cnt_q <= '0;
      enq_req_q    <= 1'b0;
      enq_qid_q    <= '0;
      deq_req_q    <= 1'b0;
      deq_qid_q    <= '0;
    end else begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      active_cnt_q <= active_cnt_d;
      enq_req_q    <= enq_accept;
      if (enq_accept) enq_qid_q <= up_enq_qid;
      deq_req_q    <= deq_issue;
      if (deq_issue) deq_qid_q <= pick_qid;
    end
  end

  assign enq_req    = enq_req_q;
  assign enq_qid    = enq_qid_q;
  assign deq_req    = deq_req_q;
  assign deq_qid    = deq_qid_q;
  assign active_cnt = active_cnt_q;

`ifdef TM_QM0_SCHED_ERR_EN
  // ---------------- protocol error capture ----------------
  logic       err_q;
  logic [1:0] err_code_q;
  logic       err_hit;
  logic [1:0] err_hit_code;
  logic       enq_head_active;

  // Activity of the enqueue head as seen after any same-cycle dequeue clear.
  assign enq_head_active = active_q[enq_head] &
                           ~(deq_pop & ~deq_from_emptyp2 & (deq_head == enq_head));

  always_comb begin
    err_hit      = 1'b0;
    err_hit_code = ERR_NONE;
    if ((enq_ack && enq_empty) || (deq_ack && deq_empty)) begin
      err_hit      = 1'b1;
      err_hit_code = ERR_ACK_EMPTY;
    end else if (deq_pop && !active_q[deq_head]) begin
      err_hit      = 1'b1;
      err_hit_code = ERR_DEQ_INACTIVE;
    end else if (enq_pop && enq_to_empty && enq_head_active) begin
      err_hit      = 1'b1;
      err_hit_code = ERR_ENQ_ACTIVE;
    end
  end

  // Only the first error is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (!err_q && err_hit) begin
      err_q      <= 1'b1;
      err_code_q <= err_hit_code;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
`endif

endmodule
